// File: rtl/countdown_timer.sv
// Loadable saturating down-counter with pause, synchronous clear and optional
// auto-reload. Emits a one-cycle done pulse in the cycle the count first reads 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | stopped; accepts load and start
// S_RUN  | decrementing once per clock
// S_HOLD | paused, count frozen, still busy
// S_DONE | single expiry cycle with done high; reload or return to idle
module countdown_timer #(
   parameter int MOD         = 100,
   parameter int BITS        = $clog2(MOD),
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            load_i,
   input  logic [BITS-1:0] load_val_i,
   input  logic            start_i,
   input  logic            pause_i,
   output logic [BITS-1:0] count_out_o,
   output logic            busy_o,
   output logic            done_o
);

   localparam logic [BITS-1:0] MAX_VAL = BITS'(MOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [BITS-1:0] count_q, count_d;
   logic [BITS-1:0] reload_q, reload_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [BITS-1:0] load_clamp;

   assign load_clamp = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      if (clear_i) begin
         state_d = S_IDLE;
         count_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (load_i) begin
                  count_d  = load_clamp;
                  reload_d = load_clamp;
               end
               if (start_i) begin
                  state_d = (count_d != '0) ? S_RUN : S_DONE;
               end
            end
            // Leaving HOLD counts on the same edge, so each held cycle costs one cycle.
            S_RUN, S_HOLD: begin
               if (pause_i) begin
                  state_d = S_HOLD;
               end else if (count_q <= BITS'(1)) begin
                  count_d = '0;
                  state_d = S_DONE;
               end else begin
                  count_d = count_q - BITS'(1);
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               if (load_i) begin
                  count_d  = load_clamp;
                  reload_d = load_clamp;
               end
               if (AUTO_RELOAD && (reload_d != '0)) begin
                  count_d = reload_d;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               count_d = '0;
            end
         endcase
      end
      busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign count_out_o = count_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
